pocq_sched: RTL and testbench
=============================

Name: pocq_sched

Overview:
- Parametrised point-of-coherence queue for the HN-F. Successor to the single-port, flag-only POCQ.
- Holds up to DEPTH outstanding requests, each with a per-entry state (FREE/SLEEP/READY/ISSUED).
- Serialises same-cacheline requests by sleeping younger ones, and dispatches READY entries downstream over a valid/ready handshake.
- In the same cycle it applies ReadNoSnp in-place replacement and CompAck release, on distinct entries, with no mutual-exclusion restriction.

Parameters:
- DEPTH, 16, number of entries; power of two, ≥2.
- ADDR_W, 48, request address width (must equal the reqflit_t Addr width).
- LINE_OFF_W, 6, cacheline offset bits ignored by hazard compare.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  new request offered.
- req_ready  out  1  queue can accept; equals !full.
- req_flit  in  reqflit_t  request payload.
- rsp_valid  in  1  response (CompAck) present; always accepted.
- rsp_flit  in  rspflit_t  response payload.
- rns_valid  in  1  ReadNoSnp replacement present; always accepted.
- rns_flit  in  reqflit_t  replacement payload.
- iss_valid  out  1  a READY entry is offered downstream.
- iss_ready  in  1  downstream accepts.
- iss_flit  out  reqflit_t  payload of the offered entry.
- iss_idx  out  $clog2(DEPTH)  index of the offered entry.
- occupancy  out  $clog2(DEPTH)+1  number of non-FREE entries.
- empty  out  1  occupancy==0.
- full  out  1  occupancy==DEPTH.
- err_unmatched  out  1  one-cycle pulse when an rsp or rns matches no entry.

Behaviour:
- Reset (reset low, asynchronous):
  - All entries go FREE and buffers are zeroed.
  - Output values during and after reset: occupancy=0, empty=1, full=0, req_ready=1, iss_valid=0, iss_flit=0, iss_idx=0, err_unmatched=0.
- Reset asserted mid-transaction discards all entries with no further outputs.
- Allocation:
  - The request is accepted when req_valid && req_ready.
  - It is written to the lowest-index FREE entry. A free-slot index of 0 is a legal result, unlike the old first-free search.
  - Allocation uses pre-edge state, so a release in the same cycle does not free a slot for it.
- Hazard check at allocation:
  - Line address is Addr[ADDR_W-1:LINE_OFF_W].
  - If any non-FREE entry holds the same line address, the new entry enters SLEEP; otherwise it enters READY.
  - An entry being released in the same cycle is excluded from the compare, unless that release wakes a sleeper (the woken entry still conflicts).
- Dispatch:
  - iss_valid=1 whenever any entry is READY; the lowest-index READY entry is presented.
  - Outputs are combinational from registered state.
  - When iss_valid && iss_ready, that entry moves READY→ISSUED at the clock edge.
  - iss_flit and iss_idx must stay stable while iss_valid && !iss_ready, unless a lower-index entry becomes READY. Such preemption is allowed because it is not yet a handshake.
- Replace:
  - rns_valid matches the non-FREE entry with TxnID==rns_flit.ReturnTxnID and SrcID==rns_flit.StashNID_ReturnNID (lowest index if several).
  - The matched buffer is overwritten with rns_flit; its state is unchanged.
- Release:
  - rsp_valid matches the ISSUED entry with TxnID==rsp_flit.TxnID and SrcID==rsp_flit.TgtID.
  - The matched entry goes to FREE and its buffer is zeroed.
  - The lowest-index SLEEP entry with the same line address moves to READY in the same edge.
- Simultaneous events:
  - Alloc, dispatch, replace and release may all occur in one cycle, provided each targets a different entry.
  - If replace and release hit the same entry, release wins and the replace is dropped without error.
- Unmatched rsp or rns: err_unmatched pulses high the following cycle; no state change.
- Occupancy is a registered count: +1 on alloc, -1 on release, unchanged when both occur.

Decomposition:
- Shared package chi_pkg:
  - reqflit_t and rspflit_t, including the fields TxnID, SrcID, TgtID, Addr, ReturnTxnID, StashNID_ReturnNID.
  - pocq_state_e {FREE, SLEEP, READY, ISSUED}.
- Sub-module pocq_prio_enc #(DEPTH):
  - Lowest-set-bit encoder producing a found flag and an index.
  - Instantiated four times: free slot, dispatch pick, replace match, wake pick.

Test Plan:
- Reset, then alloc Addr=0x1000 TxnID=1 SrcID=2 → entry 0 READY, iss_valid=1, iss_idx=0, occupancy=1.
- Alloc Addr 0x1000 then 0x1020 (same line) → entry 1 SLEEP. Issue entry 0, then rsp TxnID=1 TgtID=2 → entry 0 FREE and entry 1 READY on the same edge.
- Fill 16 entries → full=1, req_ready=0; a 17th req_valid is held. Release one → req_ready=1 next cycle, occupancy 16→15.
- Same cycle: alloc to a new line, replace on entry 3 (ReturnTxnID match), release on entry 5 → all three take effect and occupancy is unchanged.
- rsp with TxnID=0x7F matching no entry → err_unmatched=1 for exactly one cycle, state unchanged.
- Drop reset low while iss_valid=1 and iss_ready=0 → iss_valid=0 and empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/chi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chi_pkg
// Description : Shared CHI flit types and POCQ entry state for the HN-F.
//               reqflit_t : request flit (also used for ReadNoSnp replacement)
//               rspflit_t : response flit (CompAck)
//               pocq_state_e : per-entry POCQ state
// Revision    : 1.0 - initial parametrised POCQ support
// ============================================================================
package chi_pkg;

  localparam int c_nodeid_w = 7;
  localparam int c_txnid_w  = 8;
  localparam int c_addr_w   = 48;

  typedef struct packed {
    logic [6:0]            Opcode;
    logic [c_nodeid_w-1:0] TgtID;
    logic [c_nodeid_w-1:0] SrcID;
    logic [c_txnid_w-1:0]  TxnID;
    logic [c_nodeid_w-1:0] StashNID_ReturnNID;
    logic [c_txnid_w-1:0]  ReturnTxnID;
    logic [c_addr_w-1:0]   Addr;
  } reqflit_t;

  typedef struct packed {
    logic [4:0]            Opcode;
    logic [c_nodeid_w-1:0] TgtID;
    logic [c_nodeid_w-1:0] SrcID;
    logic [c_txnid_w-1:0]  TxnID;
  } rspflit_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    SLEEP  = 2'd1,
    READY  = 2'd2,
    ISSUED = 2'd3
  } pocq_state_e;

endpackage
`default_nettype wire

// File: rtl/pocq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : pocq_prio_enc
// Description : Lowest-set-bit priority encoder.
//   i_req   [DEPTH]          request vector
//   o_found                  any bit of i_req set
//   o_idx   [$clog2(DEPTH)]  index of the lowest set bit (0 when none set)
// Revision    : 1.0 - initial
// ============================================================================
module pocq_prio_enc #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]         i_req,
  output logic                     o_found,
  output logic [$clog2(DEPTH)-1:0] o_idx
);

  localparam int c_idx_w = $clog2(DEPTH);

  assign o_found = |i_req;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = c_idx_w'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pocq_sched.sv
`default_nettype none
// ============================================================================
// Module      : pocq_sched
// Description : HN-F point-of-coherence queue. Holds DEPTH requests, sleeps
//               younger same-line requests, dispatches READY entries over a
//               valid/ready handshake, applies ReadNoSnp replacement and
//               CompAck release concurrently on distinct entries.
//   clock, reset (async active-low)
//   req_valid/req_ready/req_flit   : request allocation
//   rsp_valid/rsp_flit             : CompAck release (always accepted)
//   rns_valid/rns_flit             : ReadNoSnp in-place replacement
//   iss_valid/iss_ready/iss_flit/iss_idx : downstream dispatch
//   occupancy/empty/full           : registered fill level
//   err_unmatched                  : pulse after an rsp/rns that hit nothing
// Revision    : 1.0 - initial parametrised, multi-event successor
// ============================================================================
module pocq_sched
  import chi_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 48,
  parameter int LINE_OFF_W = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  reqflit_t                   req_flit,
  input  logic                       rsp_valid,
  input  rspflit_t                   rsp_flit,
  input  logic                       rns_valid,
  input  reqflit_t                   rns_flit,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output reqflit_t                   iss_flit,
  output logic [$clog2(DEPTH)-1:0]   iss_idx,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       empty,
  output logic                       full,
  output logic                       err_unmatched
);

  localparam int c_idx_w  = $clog2(DEPTH);
  localparam int c_occ_w  = c_idx_w + 1;
  localparam int c_line_w = ADDR_W - LINE_OFF_W;
  localparam logic [c_occ_w-1:0] c_full_cnt = c_occ_w'(DEPTH);
  localparam logic [c_occ_w-1:0] c_one      = c_occ_w'(1);

  pocq_state_e             r_state [DEPTH];
  reqflit_t                r_buf   [DEPTH];
  logic [c_occ_w-1:0]      r_occ;
  logic                    r_err;

  logic [c_line_w-1:0]     w_line  [DEPTH];
  logic [c_line_w-1:0]     w_req_line;
  logic [c_line_w-1:0]     w_rel_line;
  logic [DEPTH-1:0]        w_free_vec, w_rdy_vec, w_rel_vec, w_rel_oh;
  logic [DEPTH-1:0]        w_rns_vec, w_wake_vec, w_haz_vec;
  logic                    w_free_found, w_pick_found, w_rns_found, w_wake_found;
  logic [c_idx_w-1:0]      w_free_idx, w_pick_idx, w_rns_idx, w_wake_idx;
  logic                    w_rel_found, w_alloc, w_issue, w_rns_take, w_haz;
  logic                    w_unused;

  assign w_req_line = req_flit.Addr[ADDR_W-1:LINE_OFF_W];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign w_line[g]     = r_buf[g].Addr[ADDR_W-1:LINE_OFF_W];
    assign w_free_vec[g] = (r_state[g] == FREE);
    assign w_rdy_vec[g]  = (r_state[g] == READY);
    assign w_rel_vec[g]  = rsp_valid && (r_state[g] == ISSUED) &&
                           (r_buf[g].TxnID == rsp_flit.TxnID) &&
                           (r_buf[g].SrcID == rsp_flit.TgtID);
    assign w_rns_vec[g]  = rns_valid && (r_state[g] != FREE) &&
                           (r_buf[g].TxnID == rns_flit.ReturnTxnID) &&
                           (r_buf[g].SrcID == rns_flit.StashNID_ReturnNID);
    assign w_wake_vec[g] = w_rel_found && (r_state[g] == SLEEP) &&
                           (w_line[g] == w_rel_line);
    // The entry retiring this edge no longer blocks the new request; a
    // sleeper it wakes is still non-FREE and keeps the line serialised.
    assign w_haz_vec[g]  = (r_state[g] != FREE) && !w_rel_oh[g] &&
                           (w_line[g] == w_req_line);
  end

  // Release target as one-hot lowest match, so its line can be muxed out
  // without a further encoder.
  assign w_rel_found = |w_rel_vec;
  assign w_rel_oh    = w_rel_vec & (~w_rel_vec + DEPTH'(1));

  always_comb begin
    w_rel_line = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rel_oh[i]) w_rel_line = w_rel_line | w_line[i];
    end
  end

  pocq_prio_enc #(.DEPTH(DEPTH)) u_free (
    .i_req(w_free_vec), .o_found(w_free_found), .o_idx(w_free_idx));
  pocq_prio_enc #(.DEPTH(DEPTH)) u_pick (
    .i_req(w_rdy_vec),  .o_found(w_pick_found), .o_idx(w_pick_idx));
  pocq_prio_enc #(.DEPTH(DEPTH)) u_rns (
    .i_req(w_rns_vec),  .o_found(w_rns_found),  .o_idx(w_rns_idx));
  pocq_prio_enc #(.DEPTH(DEPTH)) u_wake (
    .i_req(w_wake_vec), .o_found(w_wake_found), .o_idx(w_wake_idx));

  assign w_haz      = |w_haz_vec;
  assign w_alloc    = req_valid && req_ready;
  assign w_issue    = w_pick_found && iss_ready;
  // Release beats replace on the same entry; the replace is silently dropped.
  assign w_rns_take = w_rns_found && !w_rel_oh[w_rns_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= FREE;
        r_buf[i]   <= '0;
      end
      r_occ <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue && (w_pick_idx == c_idx_w'(i))) r_state[i] <= ISSUED;
        if (w_rel_oh[i])                            r_state[i] <= FREE;
        if (w_wake_found && (w_wake_idx == c_idx_w'(i))) r_state[i] <= READY;
        if (w_alloc && (w_free_idx == c_idx_w'(i)))
          r_state[i] <= w_haz ? SLEEP : READY;

        if (w_rel_oh[i])
          r_buf[i] <= '0;
        else if (w_alloc && (w_free_idx == c_idx_w'(i)))
          r_buf[i] <= req_flit;
        else if (w_rns_take && (w_rns_idx == c_idx_w'(i)))
          r_buf[i] <= rns_flit;
      end

      case ({w_alloc, w_rel_found})
        2'b10:   r_occ <= r_occ + c_one;
        2'b01:   r_occ <= r_occ - c_one;
        default: r_occ <= r_occ;
      endcase

      r_err <= (rsp_valid && !w_rel_found) || (rns_valid && !w_rns_found);
    end
  end

  assign occupancy     = r_occ;
  assign empty         = (r_occ == '0);
  assign full          = (r_occ == c_full_cnt);
  assign req_ready     = !full;
  assign iss_valid     = w_pick_found;
  assign iss_idx       = w_pick_idx;
  assign iss_flit      = w_pick_found ? r_buf[w_pick_idx] : '0;
  assign err_unmatched = r_err;

  // Fields that play no part in matching; a free slot always exists when
  // req_ready is high, so its found flag is redundant.
  assign w_unused = ^{rsp_flit.SrcID, rsp_flit.Opcode, w_free_found};

endmodule
`default_nettype wire

// File: tb/tb_pocq_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pocq_sched
// Description : Scoreboard bench for pocq_sched. A behavioural queue model
//               predicts the post-edge outputs each cycle; a monitor pops
//               and compares them on the falling edge.
// Revision    : 1.0 - initial
// ============================================================================
module tb_pocq_sched;
  import chi_pkg::*;

  localparam int DEPTH = 16;
  localparam int S_FREE = 0, S_SLEEP = 1, S_READY = 2, S_ISSUED = 3;

  logic        clock, reset;
  logic        req_valid, req_ready, rsp_valid, rns_valid;
  logic        iss_valid, iss_ready, empty, full, err_unmatched;
  reqflit_t    req_flit, rns_flit, iss_flit;
  rspflit_t    rsp_flit;
  logic [3:0]  iss_idx;
  logic [4:0]  occupancy;

  pocq_sched #(.DEPTH(DEPTH), .ADDR_W(48), .LINE_OFF_W(6)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
    .rsp_valid(rsp_valid), .rsp_flit(rsp_flit),
    .rns_valid(rns_valid), .rns_flit(rns_flit),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_flit(iss_flit),
    .iss_idx(iss_idx), .occupancy(occupancy), .empty(empty), .full(full),
    .err_unmatched(err_unmatched));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  int       m_st  [DEPTH];
  reqflit_t m_buf [DEPTH];
  int       m_occ;
  bit       m_err;
  int       txn_ctr = 16;

  typedef struct {
    int       occ;
    bit       vld;
    int       idx;
    reqflit_t flit;
    bit       err;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [47:0] line_of(logic [47:0] a);
    return a / 64;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_st[k] = S_FREE;
      m_buf[k] = '0;
    end
    m_occ = 0;
    m_err = 0;
  endfunction

  // TxnIDs unique among live entries; 0x7F is kept for deliberate misses.
  function automatic logic [7:0] next_txn();
    bit clash;
    do begin
      txn_ctr = (txn_ctr + 1) % 127;
      clash = 0;
      for (int k = 0; k < DEPTH; k++)
        if (m_st[k] != S_FREE && m_buf[k].TxnID == 8'(txn_ctr)) clash = 1;
    end while (clash);
    return 8'(txn_ctr);
  endfunction

  function automatic reqflit_t mk_req(logic [47:0] a, logic [7:0] t, logic [6:0] s);
    reqflit_t r;
    r = '0;
    r.Addr = a;
    r.TxnID = t;
    r.SrcID = s;
    r.TgtID = 7'h10;
    r.Opcode = 7'h04;
    return r;
  endfunction

  function automatic void model_edge(bit rv, reqflit_t rq, bit sv, rspflit_t rs,
                                     bit nv, reqflit_t rn, bit ir);
    int rel = -1, rep = -1, wake = -1, pick = -1, slot = -1;
    bit sleep_new = 0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sv && m_st[k] == S_ISSUED && m_buf[k].TxnID == rs.TxnID &&
          m_buf[k].SrcID == rs.TgtID) rel = k;
      if (nv && m_st[k] != S_FREE && m_buf[k].TxnID == rn.ReturnTxnID &&
          m_buf[k].SrcID == rn.StashNID_ReturnNID) rep = k;
      if (m_st[k] == S_READY) pick = k;
      if (m_st[k] == S_FREE) slot = k;
    end
    if (!(rv && m_occ < DEPTH)) slot = -1;
    if (rel >= 0)
      for (int k = DEPTH - 1; k >= 0; k--)
        if (m_st[k] == S_SLEEP && line_of(m_buf[k].Addr) == line_of(m_buf[rel].Addr))
          wake = k;
    if (slot >= 0)
      for (int k = 0; k < DEPTH; k++)
        if (k != rel && m_st[k] != S_FREE && line_of(m_buf[k].Addr) == line_of(rq.Addr))
          sleep_new = 1;
    m_err = (sv && rel < 0) || (nv && rep < 0);
    if (pick >= 0 && ir) m_st[pick] = S_ISSUED;
    if (rep >= 0 && rep != rel) m_buf[rep] = rn;
    if (rel >= 0) begin
      m_st[rel] = S_FREE;
      m_buf[rel] = '0;
      m_occ--;
    end
    if (wake >= 0) m_st[wake] = S_READY;
    if (slot >= 0) begin
      m_st[slot] = sleep_new ? S_SLEEP : S_READY;
      m_buf[slot] = rq;
      m_occ++;
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.occ = m_occ;
    e.err = m_err;
    e.vld = 0;
    e.idx = 0;
    e.flit = '0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (m_st[k] == S_READY) begin
        e.vld = 1;
        e.idx = k;
        e.flit = m_buf[k];
      end
    exp_q.push_back(e);
  endfunction

  task automatic step();
    bit rv, sv, nv, ir;
    reqflit_t rq, rn;
    rspflit_t rs;
    rv = req_valid; rq = req_flit; sv = rsp_valid; rs = rsp_flit;
    nv = rns_valid; rn = rns_flit; ir = iss_ready;
    @(posedge clock);
    #1;
    model_edge(rv, rq, sv, rs, nv, rn, ir);
    push_exp();
  endtask

  function automatic rspflit_t rsp_for(int k);
    rspflit_t r;
    r = '0;
    r.TxnID = m_buf[k].TxnID;
    r.TgtID = m_buf[k].SrcID;
    r.SrcID = 7'h22;
    r.Opcode = 5'h02;
    return r;
  endfunction

  function automatic reqflit_t rns_for(int k);
    reqflit_t r;
    logic [47:0] a;
    a = (m_buf[k].Addr / 64) * 64 + 48'($urandom_range(0, 63));
    r = mk_req(a, next_txn(), 7'($urandom_range(0, 3)));
    r.ReturnTxnID = m_buf[k].TxnID;
    r.StashNID_ReturnNID = m_buf[k].SrcID;
    return r;
  endfunction

  function automatic void idle_inputs();
    req_valid = 0; rsp_valid = 0; rns_valid = 0; iss_ready = 0;
    req_flit = '0; rsp_flit = '0; rns_flit = '0;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("occupancy", occupancy, e.occ);
        check("empty", empty, e.occ == 0);
        check("full", full, e.occ == DEPTH);
        check("req_ready", req_ready, e.occ != DEPTH);
        check("iss_valid", iss_valid, e.vld);
        if (e.vld) begin
          check("iss_idx", iss_idx, e.idx);
          check("iss_flit", iss_flit, e.flit);
        end
        check("err_unmatched", err_unmatched, e.err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int q[$];
    int guard;
    idle_inputs();
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_occupancy", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_iss_idx", iss_idx, 0);
    check("rst_iss_flit", iss_flit, 0);
    check("rst_err", err_unmatched, 0);
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b1;

    // Single alloc lands in entry 0 READY; same-line follower sleeps.
    req_valid = 1; req_flit = mk_req(48'h1000, 8'h01, 7'h02); step();
    req_flit = mk_req(48'h1020, 8'h03, 7'h02); step();
    req_valid = 0; iss_ready = 1; step();
    iss_ready = 0; rsp_valid = 1; rsp_flit = rsp_for(0); step();
    rsp_valid = 0; step();
    iss_ready = 1; step();
    iss_ready = 0; rsp_valid = 1; rsp_flit = rsp_for(1); step();

    // CompAck that matches nothing: one-cycle error pulse.
    rsp_flit.TxnID = 8'h7F; step();
    rsp_valid = 0; step(); step();

    // Fill all entries on distinct lines, hold a 17th, then release.
    iss_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      req_valid = 1; req_flit = mk_req(48'h2000 + 48'(i) * 64, next_txn(), 7'(i)); step();
    end
    req_flit = mk_req(48'h3000, next_txn(), 7'h05);
    step(); step(); step();
    rsp_valid = 1; rsp_flit = rsp_for(0); step();
    rsp_valid = 0; step();
    req_valid = 0; step();
    rsp_valid = 1; rsp_flit = rsp_for(1); step();

    // Alloc + replace(3) + release(5) in one cycle, then replace/release clash on 6.
    req_valid = 1; req_flit = mk_req(48'h4000, next_txn(), 7'h01);
    rns_valid = 1; rns_flit = rns_for(3);
    rsp_valid = 1; rsp_flit = rsp_for(5); step();
    req_valid = 0; rns_valid = 0; rsp_valid = 0; step();
    rns_valid = 1; rns_flit = rns_for(6);
    rsp_valid = 1; rsp_flit = rsp_for(6); step();
    rns_valid = 0; rsp_valid = 0; step();

    // Randomised traffic on a handful of lines to provoke hazards.
    for (int c = 0; c < 2000; c++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_flit = mk_req(48'h2000 + 48'($urandom_range(0, 5)) * 64 + 48'($urandom_range(0, 63)),
                        next_txn(), 7'($urandom_range(0, 3)));
      iss_ready = ($urandom_range(0, 9) < 6);
      rsp_valid = ($urandom_range(0, 9) < 4);
      q.delete();
      for (int k = 0; k < DEPTH; k++) if (m_st[k] == S_ISSUED) q.push_back(k);
      if (q.size() > 0 && $urandom_range(0, 9) < 9)
        rsp_flit = rsp_for(q[$urandom_range(0, q.size() - 1)]);
      else begin
        rsp_flit = '0; rsp_flit.TxnID = 8'h7F; rsp_flit.TgtID = 7'($urandom_range(0, 3));
      end
      rns_valid = ($urandom_range(0, 9) < 2);
      q.delete();
      for (int k = 0; k < DEPTH; k++) if (m_st[k] != S_FREE) q.push_back(k);
      if (q.size() > 0 && $urandom_range(0, 9) < 8)
        rns_flit = rns_for(q[$urandom_range(0, q.size() - 1)]);
      else begin
        rns_flit = mk_req(48'h9000, 8'h00, 7'h00); rns_flit.ReturnTxnID = 8'h7F;
      end
      step();
    end

    // Drain, then leave one entry READY but unaccepted and reset mid-cycle.
    idle_inputs();
    guard = 0;
    while (m_occ > 0 && guard < 500) begin
      guard++;
      iss_ready = 1;
      rsp_valid = 0;
      for (int k = DEPTH - 1; k >= 0; k--)
        if (m_st[k] == S_ISSUED) begin
          rsp_valid = 1; rsp_flit = rsp_for(k);
        end
      step();
    end
    check("drain_occupancy", occupancy, 0);
    idle_inputs();
    req_valid = 1; req_flit = mk_req(48'h5000, next_txn(), 7'h01); step();
    req_valid = 0; step();
    #6;
    reset = 1'b0;
    #1;
    check("async_iss_valid", iss_valid, 0);
    check("async_empty", empty, 1);
    check("async_occupancy", occupancy, 0);
    check("async_req_ready", req_ready, 1);
    check("async_iss_flit", iss_flit, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
